// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and helpers for the UART receiver.
// Receiver states, parity modes, baud divider helper, FIFO entry layout.
package uart_rx_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    typedef struct packed {
        logic                     brk;
        logic                     frameErr;
        logic                     parityErr;
        logic [MAX_DATA_BITS-1:0] data;
    } rx_entry_t;

    // Rounded clocks per oversample tick, never below 1.
    function automatic int calc_div(
        input longint clkHz,
        input longint baud,
        input longint os
    );
        longint d;
        longint q;
        d = baud * os;
        q = (clkHz + d / 2) / d;
        return (q < 1) ? 1 : int'(q);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word fall-through FIFO, power-of-two depth.
// Ports: push/din, pop/dout (head), full, empty.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic             doPush;
    logic             doPop;

    // Extra pointer bit tells full from empty when the indices match.
    assign empty  = wrPtr == rdPtr;
    assign full   = (wrPtr[AW] != rdPtr[AW]) &&
                    (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign dout   = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with flags, FIFO and idle detect.
// Ports: rxd in; rx_data/flags/rx_valid/rx_ready out FIFO; overrun, idle, eop.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 460800,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int IDLE_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_break,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun,
    output logic                 rx_idle,
    output logic                 rx_endofpacket
);

    localparam int DIV     = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int DIV_W   = $clog2(DIV + 1);
    localparam int TC_W    = $clog2(OVERSAMPLE);
    localparam int GAP_MAX = IDLE_BITS * OVERSAMPLE;
    localparam int GAP_W   = $clog2(GAP_MAX + 1);
    localparam int EW      = $bits(rx_entry_t);

    // Tick generator
    logic [DIV_W-1:0] divCnt;
    logic             tick;

    assign tick = divCnt == DIV_W'(DIV - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    divCnt <= '0;
        else if (tick) divCnt <= '0;
        else           divCnt <= divCnt + 1'b1;
    end

    // Synchroniser, majority sampler, start arming
    logic [1:0] syncFf;
    logic [1:0] syncVld;
    logic [2:0] samples;
    logic       armed;
    logic       bitVal;

    assign bitVal = (samples[0] & samples[1]) |
                    (samples[0] & samples[2]) |
                    (samples[1] & samples[2]);

    // armed only rises once a genuine high has been seen after reset,
    // so a line held low through reset cannot start a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncFf  <= 2'b11;
            syncVld <= 2'b00;
            samples <= 3'b111;
            armed   <= 1'b0;
        end else begin
            syncFf  <= {syncFf[0], rxd};
            syncVld <= {syncVld[0], 1'b1};
            if (tick) samples <= {samples[1:0], syncFf[1]};
            if (syncVld[1] && syncFf[1]) armed <= 1'b1;
        end
    end

    // Frame FSM
    rx_state_t            state;
    logic [TC_W-1:0]      tickCnt;
    logic [3:0]           bitIdx;
    logic                 stopIdx;
    logic [DATA_BITS-1:0] shreg;
    logic                 parErr;
    logic                 frameErr;
    logic                 firstStopLow;
    logic                 pushReq;
    rx_entry_t            pushEntry;
    logic                 bitEnd;
    logic                 halfBit;
    logic                 stopFrameErr;
    logic                 stopFirstLow;
    logic                 lastStop;

    assign bitEnd       = tickCnt == TC_W'(OVERSAMPLE - 1);
    assign halfBit      = tickCnt == TC_W'(OVERSAMPLE / 2 - 1);
    assign stopFrameErr = frameErr | ~bitVal;
    assign stopFirstLow = (stopIdx == 1'b0) ? ~bitVal : firstStopLow;
    assign lastStop     = stopIdx == 1'(STOP_BITS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tickCnt      <= '0;
            bitIdx       <= '0;
            stopIdx      <= 1'b0;
            shreg        <= '0;
            parErr       <= 1'b0;
            frameErr     <= 1'b0;
            firstStopLow <= 1'b0;
            pushReq      <= 1'b0;
            pushEntry    <= '0;
        end else begin
            pushReq <= 1'b0;
            if (tick) begin
                unique case (state)
                    IDLE: begin
                        if (armed && !bitVal) begin
                            state   <= START;
                            tickCnt <= '0;
                        end
                    end
                    START: begin
                        if (halfBit) begin
                            tickCnt <= '0;
                            if (!bitVal) begin
                                state        <= DATA;
                                bitIdx       <= '0;
                                stopIdx      <= 1'b0;
                                parErr       <= 1'b0;
                                frameErr     <= 1'b0;
                                firstStopLow <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            tickCnt <= tickCnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (bitEnd) begin
                            tickCnt <= '0;
                            shreg   <= {bitVal, shreg[DATA_BITS-1:1]};
                            bitIdx  <= bitIdx + 1'b1;
                            if (bitIdx == 4'(DATA_BITS - 1))
                                state <= (PARITY == PAR_NONE) ? STOP : PAR;
                        end else begin
                            tickCnt <= tickCnt + 1'b1;
                        end
                    end
                    PAR: begin
                        if (bitEnd) begin
                            tickCnt <= '0;
                            parErr  <= ((^shreg) ^ bitVal) !=
                                       (PARITY == PAR_ODD);
                            state   <= STOP;
                        end else begin
                            tickCnt <= tickCnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (bitEnd) begin
                            tickCnt <= '0;
                            if (lastStop) begin
                                pushReq   <= 1'b1;
                                pushEntry <= '{
                                    brk:       (shreg == '0) && stopFirstLow,
                                    frameErr:  stopFrameErr,
                                    parityErr: parErr,
                                    data:      MAX_DATA_BITS'(shreg)
                                };
                                // A low final stop may be a break; wait
                                // for the line to recover before rearming.
                                state <= bitVal ? IDLE : WAIT_HIGH;
                            end else begin
                                frameErr     <= stopFrameErr;
                                firstStopLow <= stopFirstLow;
                                stopIdx      <= 1'b1;
                            end
                        end else begin
                            tickCnt <= tickCnt + 1'b1;
                        end
                    end
                    WAIT_HIGH: begin
                        if (bitVal) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Gap counter and end-of-packet
    logic [GAP_W-1:0] gapCnt;
    logic             frameDone;
    logic             eopHit;

    assign eopHit  = (state == IDLE) && tick && frameDone &&
                     (gapCnt == GAP_W'(GAP_MAX - 1));
    assign rx_idle = (state == IDLE) && (gapCnt == GAP_W'(GAP_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gapCnt         <= GAP_W'(GAP_MAX);
            frameDone      <= 1'b0;
            rx_endofpacket <= 1'b0;
        end else begin
            if (state != IDLE)
                gapCnt <= '0;
            else if (tick && gapCnt != GAP_W'(GAP_MAX))
                gapCnt <= gapCnt + 1'b1;
            rx_endofpacket <= eopHit;
            if (eopHit)       frameDone <= 1'b0;
            else if (pushReq) frameDone <= 1'b1;
        end
    end

    // Output FIFO
    rx_entry_t head;
    logic      full;
    logic      empty;
    logic      pop;

    assign rx_valid   = !empty;
    assign pop        = rx_valid && rx_ready;
    assign rx_overrun = pushReq && full && !pop;

    uart_rx_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pushReq),
        .din   (pushEntry),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign rx_data       = rx_valid ? head.data[DATA_BITS-1:0] : '0;
    assign rx_parity_err = rx_valid && head.parityErr;
    assign rx_frame_err  = rx_valid && head.frameErr;
    assign rx_break      = rx_valid && head.brk;

    if (DATA_BITS < MAX_DATA_BITS) begin : gPad
        logic unusedHi;
        assign unusedHi = ^head.data[MAX_DATA_BITS-1:DATA_BITS];
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed bench for uart_rx_core (8N1 and 7E2 instances).
// Serial frames are driven bit by bit; popped words are logged and compared.
module tb_uart_rx_core;

    localparam int BITCLK = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd8;
    logic       rxd7;
    logic       rdy8;
    logic       rdy7;

    logic [7:0] data8;
    logic       pe8, fe8, brk8, v8, ov8, idle8, eop8;
    logic [6:0] data7;
    logic       pe7, fe7, brk7, v7, ov7, idle7, eop7;

    always #5 clk = ~clk;

    uart_rx_core #(
        .CLK_FREQ   (100000000),
        .BAUD       (1562500),
        .OVERSAMPLE (16),
        .DATA_BITS  (8),
        .PARITY     (0),
        .STOP_BITS  (1),
        .FIFO_DEPTH (4),
        .IDLE_BITS  (2)
    ) dut8 (
        .clk            (clk),
        .rst_n          (rst_n),
        .rxd            (rxd8),
        .rx_data        (data8),
        .rx_parity_err  (pe8),
        .rx_frame_err   (fe8),
        .rx_break       (brk8),
        .rx_valid       (v8),
        .rx_ready       (rdy8),
        .rx_overrun     (ov8),
        .rx_idle        (idle8),
        .rx_endofpacket (eop8)
    );

    uart_rx_core #(
        .CLK_FREQ   (100000000),
        .BAUD       (1562500),
        .OVERSAMPLE (16),
        .DATA_BITS  (7),
        .PARITY     (2),
        .STOP_BITS  (2),
        .FIFO_DEPTH (4),
        .IDLE_BITS  (2)
    ) dut7 (
        .clk            (clk),
        .rst_n          (rst_n),
        .rxd            (rxd7),
        .rx_data        (data7),
        .rx_parity_err  (pe7),
        .rx_frame_err   (fe7),
        .rx_break       (brk7),
        .rx_valid       (v7),
        .rx_ready       (rdy7),
        .rx_overrun     (ov7),
        .rx_idle        (idle7),
        .rx_endofpacket (eop7)
    );

    // Monitor: logs every popped word and counts pulses.
    logic [11:0] q8[$];
    logic [11:0] q7[$];
    int          cyc    = 0;
    int          eopCnt = 0;
    int          eopCyc = 0;
    int          ovCnt  = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (v8 && rdy8) q8.push_back({brk8, fe8, pe8, 1'b0, data8});
        if (v7 && rdy7) q7.push_back({brk7, fe7, pe7, 2'b00, data7});
        if (eop8) begin
            eopCnt = eopCnt + 1;
            eopCyc = cyc;
        end
        if (ov8) ovCnt = ovCnt + 1;
    end

    int nTests = 0;
    int nFail  = 0;
    int rd8    = 0;
    int rd7    = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ent(input logic b, input logic f,
                                        input logic p, input logic [8:0] d);
        return {20'd0, b, f, p, d};
    endfunction

    task automatic word8(input string tag, input logic [31:0] exp);
        logic [31:0] obs;
        if (rd8 < q8.size()) begin
            obs = {20'd0, q8[rd8]};
            rd8++;
        end else begin
            obs = 32'hdead;
        end
        chk(tag, obs, exp);
    endtask

    task automatic word7(input string tag, input logic [31:0] exp);
        logic [31:0] obs;
        if (rd7 < q7.size()) begin
            obs = {20'd0, q7[rd7]};
            rd7++;
        end else begin
            obs = 32'hdead;
        end
        chk(tag, obs, exp);
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic v, input int bits);
        rxd8 = v;
        waitClk(bits * BITCLK);
    endtask

    task automatic drive7(input logic v, input int bits);
        rxd7 = v;
        waitClk(bits * BITCLK);
    endtask

    task automatic send8(input logic [7:0] d, input logic stopV);
        drive8(1'b0, 1);
        for (int i = 0; i < 8; i++) drive8(d[i], 1);
        drive8(stopV, 1);
    endtask

    task automatic send7(input logic [6:0] d, input logic p);
        drive7(1'b0, 1);
        for (int i = 0; i < 7; i++) drive7(d[i], 1);
        drive7(p, 1);
        drive7(1'b1, 2);
    endtask

    int e0;
    int o0;
    int tEnd;

    initial begin
        rst_n = 1'b0;
        rxd8  = 1'b1;
        rxd7  = 1'b1;
        rdy8  = 1'b1;
        rdy7  = 1'b1;
        waitClk(5);

        // Reset values
        chk("rst_valid", {31'd0, v8}, 0);
        chk("rst_idle", {31'd0, idle8}, 1);
        chk("rst_data", {24'd0, data8}, 0);
        chk("rst_flags", {29'd0, brk8, fe8, pe8}, 0);
        chk("rst_ovr_eop", {30'd0, ov8, eop8}, 0);
        chk("rst_idle7", {31'd0, idle7}, 1);

        rst_n = 1'b1;
        waitClk(200);
        chk("startup_no_eop", eopCnt, 0);
        chk("startup_no_word", q8.size() - rd8, 0);

        // 8N1: two back-to-back bytes
        e0 = eopCnt;
        send8(8'hA5, 1'b1);
        send8(8'h3C, 1'b1);
        tEnd = cyc;
        waitClk(300);
        chk("8n1_count", q8.size() - rd8, 2);
        word8("8n1_a5", ent(0, 0, 0, 9'h0A5));
        word8("8n1_3c", ent(0, 0, 0, 9'h03C));
        chk("8n1_eop_once", eopCnt - e0, 1);
        chk("8n1_eop_time",
            {31'd0, (eopCyc - tEnd >= 64) && (eopCyc - tEnd <= 192)}, 1);
        chk("8n1_idle", {31'd0, idle8}, 1);

        // 7E2: good parity, then bad parity
        send7(7'h55, 1'b0);
        send7(7'h55, 1'b1);
        waitClk(300);
        chk("7e2_count", q7.size() - rd7, 2);
        word7("7e2_good", ent(0, 0, 0, 9'h055));
        word7("7e2_bad", ent(0, 0, 1, 9'h055));

        // Break: zero byte, low stop, line held low
        e0 = eopCnt;
        drive8(1'b0, 20);
        chk("brk_wait_idle", {31'd0, idle8}, 0);
        drive8(1'b0, 10);
        rxd8 = 1'b1;
        waitClk(300);
        chk("brk_count", q8.size() - rd8, 1);
        word8("brk_word", ent(1, 1, 0, 9'h000));
        chk("brk_eop", eopCnt - e0, 1);
        chk("brk_idle", {31'd0, idle8}, 1);

        // Glitch shorter than half a bit
        e0 = eopCnt;
        rxd8 = 1'b0;
        waitClk(24);
        chk("glitch_idle_drop", {31'd0, idle8}, 0);
        rxd8 = 1'b1;
        waitClk(400);
        chk("glitch_no_word", q8.size() - rd8, 0);
        chk("glitch_no_eop", eopCnt - e0, 0);
        chk("glitch_idle", {31'd0, idle8}, 1);

        // Overrun: six bytes into a four-entry FIFO with no reader
        rdy8 = 1'b0;
        o0 = ovCnt;
        for (int i = 1; i <= 6; i++) send8(8'(i), 1'b1);
        waitClk(100);
        chk("ovr_pulses", ovCnt - o0, 2);
        chk("ovr_valid", {31'd0, v8}, 1);
        chk("ovr_head", {24'd0, data8}, 1);
        rdy8 = 1'b1;
        waitClk(20);
        chk("ovr_count", q8.size() - rd8, 4);
        for (int i = 1; i <= 4; i++)
            word8("ovr_drain", ent(0, 0, 0, 9'(i)));
        chk("ovr_empty", {31'd0, v8}, 0);

        // Reset during bit 3 of 0xFF
        rxd8 = 1'b0;
        waitClk(BITCLK);
        rxd8 = 1'b1;
        waitClk(BITCLK * 3 + 32);
        rst_n = 1'b0;
        waitClk(1);
        chk("rmid_idle", {31'd0, idle8}, 1);
        chk("rmid_valid", {31'd0, v8}, 0);
        waitClk(8);
        rst_n = 1'b1;
        waitClk(BITCLK * 6 + 300);
        chk("rmid_no_word", q8.size() - rd8, 0);
        send8(8'h81, 1'b1);
        waitClk(200);
        chk("rmid_count", q8.size() - rd8, 1);
        word8("rmid_81", ent(0, 0, 0, 9'h081));

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised asynchronous serial receiver for the host-to-FPGA command link.
- Configurable data width, parity, stop bits and oversampling ratio.
- Majority-vote bit sampling and start-bit glitch rejection.
- Per-word parity, framing and break flags.
- Small output FIFO with valid/ready handshake, overrun reporting and idle/end-of-packet detection.
- Sits between the board RxD pin and the command decoder.

## Interface
- `CLK_FREQ`, 100000000: clock frequency in Hz.
- `BAUD`, 460800: line rate in bit/s.
- `OVERSAMPLE`, 16: sample ticks per bit, even, 8..16.
- `DATA_BITS`, 8: data bits per word, 5..9, LSB first.
- `PARITY`, 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: output FIFO entries, power of two, ≥2.
- `IDLE_BITS`, 2: idle line time, in bit periods, before end-of-packet.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rxd` in 1: serial input, asynchronous, idle high.
- `rx_data` out `DATA_BITS`: FIFO head data.
- `rx_parity_err` out 1: head word parity mismatch; always 0 when `PARITY`=0.
- `rx_frame_err` out 1: head word had a low stop bit.
- `rx_break` out 1: head word was all-zero data with a low first stop bit.
- `rx_valid` out 1: FIFO non-empty.
- `rx_ready` in 1: consumer accepts the head word.
- `rx_overrun` out 1: one-cycle pulse; a word was dropped because the FIFO was full.
- `rx_idle` out 1: no frame in progress and the line has been idle for ≥ `IDLE_BITS` bit periods.
- `rx_endofpacket` out 1: one-cycle pulse when `rx_idle` rises after a frame.

## Operation
- **Tick generator:** `DIV = round(CLK_FREQ/(BAUD*OVERSAMPLE))`, computed at elaboration, minimum 1. A counter produces a one-clock `tick` every `DIV` clocks.
- **Input path:** `rxd` passes through a two-flop synchroniser, then a 3-sample shift register updated on `tick`. The sampled bit is the majority of the 3 samples.
- **States:** IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
  - IDLE: on a tick with a majority-low sample, go to START and clear the tick counter.
  - START: at tick count `OVERSAMPLE/2-1`, a still-low sample goes to DATA. A high sample is a false start; return to IDLE with no word and no flag.
  - DATA: sample at each bit centre (every `OVERSAMPLE` ticks), shift in LSB first. After `DATA_BITS` samples go to PAR, or to STOP if `PARITY`=0.
  - PAR: sample one bit. Error is `(^data ^ parbit) != (PARITY==1)`.
  - STOP: sample `STOP_BITS` stop bits. Any low stop bit sets the frame error.
    - The word and its flags are pushed at the final stop-bit sample.
    - Break is set when all data bits are 0 and the first stop bit is 0.
    - If the last stop bit was low, go to WAIT_HIGH; otherwise go to IDLE.
  - WAIT_HIGH: stay until the sample is high, then go to IDLE. This prevents break chains from generating phantom frames.
- **FIFO:** stores `{break, frame_err, parity_err, data}` and is first-word fall-through.
  - Pop happens when `rx_valid & rx_ready`.
  - Push when full without a pop in the same cycle: the word is dropped and `rx_overrun` pulses.
  - Push and pop in the same cycle while full: both succeed, no overrun.
  - Push and pop in the same cycle while empty: the word enters the FIFO; `rx_valid` rises the next cycle.
- **Gap counter:** cleared whenever the state is not IDLE; in IDLE it increments per tick and saturates at `IDLE_BITS*OVERSAMPLE`. `rx_idle` is high at saturation.

## Timing
- Reset values:
  - All outputs are 0 except `rx_idle`=1.
  - The gap counter resets saturated, so no end-of-packet is produced at startup.
  - The synchroniser and sample shift register reset to all-ones, so no phantom start.
  - State resets to IDLE; the FIFO resets empty.
- Synchroniser latency is 2 clocks. Start detection adds up to 1 tick.
- The push occurs on the clock after the final stop-bit sample tick. `rx_valid` and `rx_data` are updated on the following clock.
- `rx_overrun` is asserted on the same clock as the push attempt.
- `rx_endofpacket` is asserted on the clock the gap counter reaches saturation, only if a frame (valid, errored or break) ended since the last pulse.
- Reset asserted mid-frame aborts the frame immediately. After release, a line still low waits for a high-to-low edge before the next start is accepted.
- `rx_ready` may be held high permanently; one word per frame drains with no back-pressure.

## Structure
- Package `uart_rx_pkg` holds:
  - the state enum;
  - parity-mode constants `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`;
  - the `calc_div(clk, baud, os)` function;
  - the FIFO entry struct.
- Sub-module `uart_rx_fifo` is a parametric width/depth FWFT FIFO with full/empty flags and pointer wrap on power-of-two depth.
- Everything else (tick counter, synchroniser, FSM, gap counter) lives in `uart_rx_core`.

## Test plan
All scenarios use `CLK_FREQ`=100000000, `BAUD`=1562500, `OVERSAMPLE`=16, giving `DIV`=4 and 64 clocks per bit.
- **8N1 byte:** send 0xA5, then 0x3C -> `rx_data`=0xA5, then 0x3C, all flags 0. `rx_endofpacket` pulses once 128 clocks after the last stop bit; `rx_idle`=1 thereafter.
- **Even parity, 7E2:** `DATA_BITS`=7, `PARITY`=2, `STOP_BITS`=2. Send 0x55 with correct parity bit 0 -> `parity_err`=0. Send 0x55 with parity bit 1 -> word delivered with `parity_err`=1.
- **Framing and break:** send 0x00 with a low stop bit, hold low for 20 bits, then release -> exactly one word with `frame_err`=1 and `break`=1; no further words until a new start edge.
- **Glitch rejection:** drive a 1.5-bit-period-free glitch, i.e. a low pulse of 24 clocks (under half a bit) -> no word, no flags, `rx_idle` unaffected except the counter restart.
- **Overrun:** `FIFO_DEPTH`=4, `rx_ready`=0, send 6 bytes 0x01..0x06 -> `rx_overrun` pulses twice. Draining yields 0x01..0x04 in order.
- **Reset mid-frame:** assert `rst_n` low during bit 3 of 0xFF, release while `rxd` is high -> no word. The next byte 0x81 is received correctly.
